// File: rtl/voice_frame_sequencer_if.sv
// Parameter-update port: valid/ready write channel into the voice parameter store.
interface voice_frame_sequencer_if #(
    parameter int unsigned VIDX_W  = 8,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned WSEL_W  = 4
);
    logic               valid;
    logic               ready;
    logic [VIDX_W-1:0]  voice;
    logic [PHASE_W-1:0] delta;
    logic [WSEL_W-1:0]  wsel;
    logic               enable;

    // Writer side (MIDI/control logic)
    modport master (output valid, voice, delta, wsel, enable, input ready);
    // Sequencer side
    modport slave  (input valid, voice, delta, wsel, enable, output ready);
endinterface

// File: rtl/voice_frame_sequencer.sv
// Voice scheduler/mixer: per frame, walks every voice, issues its parameters to the shared
// voice chain and accumulates the returned samples with saturation into one mixed sample.
module voice_frame_sequencer #(
    parameter int unsigned NUM_VOICES = 256,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned WSEL_W     = 4,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned VOICE_LAT  = 2,
    localparam int unsigned VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    voice_frame_sequencer_if.slave     upd,
    output logic [VIDX_W-1:0]          voice_index,
    output logic [PHASE_W-1:0]         delta_phase,
    output logic [WSEL_W-1:0]          wave_select,
    output logic                       voice_strobe,
    input  logic signed [SAMPLE_W-1:0] voice_sample,
    output logic signed [ACC_W-1:0]    out_sample,
    output logic                       out_valid,
    output logic                       out_clip,
    output logic                       busy,
    output logic                       tick_missed
);

    localparam int unsigned LAT_W = (VOICE_LAT > 1) ? $clog2(VOICE_LAT) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRead, StLoad, StWait, StAccum, StDone} state_e;

    state_e                   state_q, state_d;
    logic [VIDX_W-1:0]        vctr_q;
    logic [LAT_W-1:0]         wait_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     clip_q;
    logic [NUM_VOICES-1:0]    enable_q;

    // Parameter store; deliberately not reset
    logic [PHASE_W-1:0]       delta_ram [NUM_VOICES];
    logic [WSEL_W-1:0]        wsel_ram  [NUM_VOICES];

    logic                     last_voice;
    logic                     upd_fire;
    logic                     upd_in_range;
    logic signed [ACC_W:0]    sum_wide;
    logic                     acc_ovf;
    logic [ACC_W-1:0]         acc_sum;

    assign last_voice   = (vctr_q == VIDX_W'(NUM_VOICES - 1));
    assign upd_fire     = upd.valid && upd.ready;
    // Out-of-range indices are accepted but dropped
    assign upd_in_range = (32'(upd.voice) < NUM_VOICES);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed READ/LOAD/WAIT/ACCUM slot per voice, muted or not
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (sample_tick) state_d = StRead;
            StRead:  state_d = StLoad;
            StLoad:  state_d = (VOICE_LAT > 1) ? StWait : StAccum;
            StWait:  if (wait_q == LAT_W'(VOICE_LAT - 2)) state_d = StAccum;
            StAccum: state_d = last_voice ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded outputs; the single RAM port is reserved for the frame during READ
    always_comb begin
        upd.ready    = (state_q != StRead);
        voice_strobe = (state_q == StLoad);
        busy         = (state_q != StIdle);
    end

    // Parameter store writes land on the accepting edge
    always_ff @(posedge clk) begin
        if (upd_fire && upd_in_range) begin
            delta_ram[upd.voice] <= upd.delta;
            wsel_ram[upd.voice]  <= upd.wsel;
        end
    end

    // Enable flops are reset so a fresh start mixes silence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= '0;
        end else if (upd_fire && upd_in_range) begin
            enable_q[upd.voice] <= upd.enable;
        end
    end

    // Saturating add of the sign-extended voice sample into the accumulator
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W + 1 - SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};
        acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        acc_sum  = acc_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    end

    // Frame datapath: issue registers, latency counter, accumulator and output sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vctr_q      <= '0;
            wait_q      <= '0;
            voice_index <= '0;
            delta_phase <= '0;
            wave_select <= '0;
            acc_q       <= '0;
            clip_q      <= 1'b0;
            out_sample  <= '0;
            out_clip    <= 1'b0;
            out_valid   <= 1'b0;
            tick_missed <= 1'b0;
        end else begin
            out_valid   <= (state_q == StDone);
            tick_missed <= sample_tick && (state_q != StIdle);
            case (state_q)
                // Registered RAM read doubles as the issue register, valid during LOAD
                StRead: begin
                    voice_index <= vctr_q;
                    delta_phase <= delta_ram[vctr_q];
                    wave_select <= wsel_ram[vctr_q];
                end
                StLoad:  wait_q <= '0;
                StWait:  wait_q <= wait_q + 1'b1;
                StAccum: begin
                    if (enable_q[vctr_q]) begin
                        acc_q  <= acc_sum;
                        clip_q <= clip_q | acc_ovf;
                    end
                    if (!last_voice) vctr_q <= vctr_q + 1'b1;
                end
                StDone: begin
                    out_sample <= acc_q;
                    out_clip   <= clip_q;
                    acc_q      <= '0;
                    clip_q     <= 1'b0;
                    vctr_q     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_frame_sequencer.sv
// Directed bench: two sequencer instances (L=2/24-bit mix and L=1/17-bit mix) driven by
// a latency-accurate voice-chain model with hand-computed frame results.
module tb_voice_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        tick_a, tick_b;
    logic        u_valid, u_sel_b, u_en;
    logic [1:0]  u_voice;
    logic [31:0] u_delta;
    logic [3:0]  u_wsel;

    voice_frame_sequencer_if #(.VIDX_W(2), .PHASE_W(32), .WSEL_W(4)) ua ();
    voice_frame_sequencer_if #(.VIDX_W(2), .PHASE_W(32), .WSEL_W(4)) ub ();

    assign ua.valid  = u_valid & ~u_sel_b;
    assign ua.voice  = u_voice;
    assign ua.delta  = u_delta;
    assign ua.wsel   = u_wsel;
    assign ua.enable = u_en;
    assign ub.valid  = u_valid & u_sel_b;
    assign ub.voice  = u_voice;
    assign ub.delta  = u_delta;
    assign ub.wsel   = u_wsel;
    assign ub.enable = u_en;

    logic [1:0]         vi_a, vi_b;
    logic [31:0]        dp_a, dp_b;
    logic [3:0]         ws_a, ws_b;
    logic               vs_a, vs_b, ov_a, ov_b, oc_a, oc_b, busy_a, busy_b, tm_a, tm_b;
    logic signed [23:0] os_a;
    logic signed [16:0] os_b;
    logic signed [15:0] smp_a, smp_b;

    voice_frame_sequencer #(
        .NUM_VOICES(4), .PHASE_W(32), .WSEL_W(4), .SAMPLE_W(16), .ACC_W(24), .VOICE_LAT(2)
    ) dut_a (
        .clk(clk), .reset(reset), .sample_tick(tick_a), .upd(ua),
        .voice_index(vi_a), .delta_phase(dp_a), .wave_select(ws_a), .voice_strobe(vs_a),
        .voice_sample(smp_a), .out_sample(os_a), .out_valid(ov_a), .out_clip(oc_a),
        .busy(busy_a), .tick_missed(tm_a)
    );

    voice_frame_sequencer #(
        .NUM_VOICES(4), .PHASE_W(32), .WSEL_W(4), .SAMPLE_W(16), .ACC_W(17), .VOICE_LAT(1)
    ) dut_b (
        .clk(clk), .reset(reset), .sample_tick(tick_b), .upd(ub),
        .voice_index(vi_b), .delta_phase(dp_b), .wave_select(ws_b), .voice_strobe(vs_b),
        .voice_sample(smp_b), .out_sample(os_b), .out_valid(ov_b), .out_clip(oc_b),
        .busy(busy_b), .tick_missed(tm_b)
    );

    // Voice-chain model: sample for the strobed voice appears VOICE_LAT cycles later,
    // filler value otherwise so a mistimed ACCUM picks up garbage
    int samp_a [4];
    int samp_b [4];
    logic signed [15:0] pipe_a0, pipe_a1, pipe_b0;
    always @(posedge clk) begin
        pipe_a0 <= vs_a ? 16'(samp_a[vi_a]) : 16'sh5A5A;
        pipe_a1 <= pipe_a0;
        pipe_b0 <= vs_b ? 16'(samp_b[vi_b]) : 16'sh5A5A;
    end
    assign smp_a = pipe_a1;
    assign smp_b = pipe_b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic upd_write(input bit b, input int v, input longint d, input int w, input bit en);
        @(posedge clk); #1;
        u_sel_b = b; u_valid = 1'b1; u_voice = 2'(v); u_delta = 32'(d); u_wsel = 4'(w);
        u_en = en;
        @(posedge clk); #1;
        u_valid = 1'b0;
    endtask

    // Frame results
    int     f_len, f_nvalid, f_missed, f_nstrobe, f_rdylow;
    longint f_out, f_clip;
    longint f_delta [8];

    // Tick one DUT and observe cycle by cycle (cycle 1 follows the edge sampling the tick)
    task automatic run_frame(input bit b, input bit hold_upd, input int tick_at,
                             input int reset_at);
        bit     watch_all;
        logic   ov, vs, oc, tm, rdy, bsy;
        longint os, dp, vi, ws;
        watch_all = (tick_at > 0) || (reset_at > 0);
        f_len = -1; f_nvalid = 0; f_missed = 0; f_nstrobe = 0; f_rdylow = 0;
        f_out = -1; f_clip = -1;
        u_sel_b = b;
        @(posedge clk); #1;
        if (b) tick_b = 1'b1; else tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0; tick_b = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (hold_upd) begin
                u_valid = 1'b1;
                if (k <= 12) begin
                    u_voice = 2'd3; u_delta = 32'd7000; u_wsel = 4'd3; u_en = 1'b1;
                end else begin
                    u_voice = 2'd0; u_delta = 32'd9000; u_wsel = 4'd0; u_en = 1'b1;
                end
            end
            if (k == tick_at) begin
                if (b) tick_b = 1'b1; else tick_a = 1'b1;
            end
            if (k == reset_at) reset = 1'b1;
            @(negedge clk);
            if (b) begin
                ov = ov_b; vs = vs_b; oc = oc_b; tm = tm_b; rdy = ub.ready; bsy = busy_b;
                os = os_b; dp = dp_b; vi = vi_b; ws = ws_b;
            end else begin
                ov = ov_a; vs = vs_a; oc = oc_a; tm = tm_a; rdy = ua.ready; bsy = busy_a;
                os = os_a; dp = dp_a; vi = vi_a; ws = ws_a;
            end
            if (vs && f_nstrobe < 8) begin
                f_delta[f_nstrobe] = dp;
                f_nstrobe++;
            end
            if (!rdy && k < 31) f_rdylow = f_rdylow | (1 << k);
            if (tm) f_missed++;
            if (k == reset_at) begin
                check("rst_mid_valid", ov, 0);
                check("rst_mid_strobe", vs, 0);
                check("rst_mid_busy", bsy, 0);
                check("rst_mid_sample", os, 0);
                check("rst_mid_clip", oc, 0);
                check("rst_mid_index", vi, 0);
                check("rst_mid_delta", dp, 0);
                check("rst_mid_wsel", ws, 0);
                check("rst_mid_missed", tm, 0);
                check("rst_mid_ready", rdy, 1);
            end
            if (ov) begin
                f_nvalid++;
                if (f_len < 0) begin
                    f_len = k; f_out = os; f_clip = oc;
                end
            end
            @(posedge clk); #1;
            tick_a = 1'b0; tick_b = 1'b0; reset = 1'b0;
            if (ov && !watch_all) break;
        end
        u_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
        u_valid = 1'b0; u_sel_b = 1'b0; u_en = 1'b0; u_voice = '0; u_delta = '0; u_wsel = '0;
        samp_a = '{0, 0, 0, 0};
        samp_b = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", ov_a, 0);
        check("rst_sample", os_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_strobe", vs_a, 0);
        check("rst_ready", ua.ready, 1);
        check("rst_missed", tm_a, 0);

        // Fresh reset: all voices muted, N*(2+L)+2 = 18 cycles
        samp_a = '{111, 222, 333, 444};
        run_frame(0, 0, 0, 0);
        check("t1_len", f_len, 18);
        check("t1_out", f_out, 0);
        check("t1_clip", f_clip, 0);
        check("t1_strobes", f_nstrobe, 4);

        // Four enabled voices
        for (int i = 0; i < 4; i++) upd_write(0, i, 1000 * (i + 1), i + 1, 1'b1);
        samp_a = '{100, -50, 25, 7};
        run_frame(0, 0, 0, 0);
        check("t2_len", f_len, 18);
        check("t2_out", f_out, 82);
        check("t2_clip", f_clip, 0);
        for (int i = 0; i < 4; i++) check($sformatf("t2_delta%0d", i), f_delta[i], 1000 * (i + 1));

        // Mute v2: same frame length
        upd_write(0, 2, 3000, 3, 1'b0);
        run_frame(0, 0, 0, 0);
        check("t4_len", f_len, 18);
        check("t4_out", f_out, 57);

        // Update port held through a frame
        run_frame(0, 1, 0, 0);
        check("t5_ready_low", f_rdylow, 32'h2222);
        check("t5_delta0", f_delta[0], 1000);
        check("t5_delta3", f_delta[3], 7000);
        check("t5_out", f_out, 57);
        run_frame(0, 0, 0, 0);
        check("t5_next_delta0", f_delta[0], 9000);
        check("t5_next_delta3", f_delta[3], 7000);
        check("t5_next_out", f_out, 57);

        // Ticks while busy are dropped
        run_frame(0, 0, 5, 0);
        check("t6_missed_busy", f_missed, 1);
        check("t6_nvalid_busy", f_nvalid, 1);
        check("t6_out", f_out, 57);
        run_frame(0, 0, 17, 0);
        check("t6_missed_done", f_missed, 1);
        check("t6_nvalid_done", f_nvalid, 1);

        // Saturation on the 17-bit mixer, L=1 (14-cycle frame)
        for (int i = 0; i < 4; i++) upd_write(1, i, 500 * (i + 1), i, 1'b1);
        samp_b = '{32767, 32767, 32767, 32767};
        run_frame(1, 0, 0, 0);
        check("t3_len", f_len, 14);
        check("t3_pos_out", f_out, 65535);
        check("t3_pos_clip", f_clip, 1);
        samp_b = '{-32768, -32768, -32768, -32768};
        run_frame(1, 0, 0, 0);
        check("t3_neg_out", f_out, -65536);
        check("t3_neg_clip", f_clip, 1);
        samp_b = '{32767, 32767, 32767, -100};
        run_frame(1, 0, 0, 0);
        check("t3_recover_out", f_out, 65435);
        check("t3_recover_clip", f_clip, 1);
        samp_b = '{0, 0, 0, 0};
        run_frame(1, 0, 0, 0);
        check("t3_zero_out", f_out, 0);
        check("t3_zero_clip", f_clip, 0);

        // Reset mid-frame aborts; parameter RAM survives, enables do not
        run_frame(0, 0, 0, 8);
        check("t7_nvalid", f_nvalid, 0);
        run_frame(0, 0, 0, 0);
        check("t7_len", f_len, 18);
        check("t7_out", f_out, 0);
        check("t7_ram_kept", f_delta[0], 9000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
